// File: rtl/pad_seq_ctrl_pkg.sv
// Shared types and sizing for the pad record/playback sequencer.
// No logic of its own beyond address helpers; no timing or backpressure implications.
package pad_seq_ctrl_pkg;

  localparam int ADDR_W    = 12;
  localparam int CODE_W    = 4;
  localparam int KEY_W     = 12;
  localparam int MEM_DEPTH = 4096;
  localparam int LEN_W     = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_REC   = 2'b01,
    MODE_PLAY  = 2'b10,
    MODE_ERASE = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REC      = 3'd1,
    ST_PLAY_RD  = 3'd2,
    ST_PLAY_LAT = 3'd3,
    ST_ERASE    = 3'd4
  } state_t;

  // Playback loops back to address 0 once the recorded length is reached.
  function automatic logic [ADDR_W-1:0] next_play_addr(input logic [ADDR_W-1:0] addr,
                                                       input logic [LEN_W-1:0]  rec_len);
    logic [LEN_W-1:0] nxt;
    nxt = {1'b0, addr} + LEN_W'(1);
    return (nxt == rec_len) ? '0 : nxt[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/pad_seq_ctrl_if.sv
// Pad, mode and memory-bus signals of the sequencer; slave = sequencer, master = pad/memory side.
// Pure wiring: no latency, no backpressure (memory answers reads in the CE cycle).
interface pad_seq_ctrl_if;
  import pad_seq_ctrl_pkg::*;

  logic [KEY_W-1:0]  Key;
  logic [1:0]        Mode;
  logic              Tick;
  logic [CODE_W-1:0] Din;
  logic [ADDR_W-1:0] Accout;
  logic              CE;
  logic              RW;
  logic [CODE_W-1:0] Dout;
  logic [CODE_W-1:0] Code;
  logic              Busy;
  logic              Full;
  logic [LEN_W-1:0]  RecLen;

  modport master (
    output Key, Mode, Tick, Din,
    input  Accout, CE, RW, Dout, Code, Busy, Full, RecLen
  );

  modport slave (
    input  Key, Mode, Tick, Din,
    output Accout, CE, RW, Dout, Code, Busy, Full, RecLen
  );

endinterface

// File: rtl/pad_key_enc.sv
// Priority encoder for the 12 pad buttons: lowest set bit wins, code = index + 1, none = 0.
// Purely combinational, zero latency; no backpressure.
module pad_key_enc
  import pad_seq_ctrl_pkg::*;
(
  input  logic [KEY_W-1:0]  key,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (key[i]) code = CODE_W'(i + 1);
    end
  end

endmodule

// File: rtl/pad_seq_ctrl.sv
// Record/play/erase sequencer for the note pad: one-cycle memory strobes, read data registered into Code.
// Latency: write/read strobe one cycle after Tick, play Code one cycle after the read strobe; Ticks during an access are dropped.
module pad_seq_ctrl
  import pad_seq_ctrl_pkg::*;
(
  input logic           CLK,
  input logic           RST,
  pad_seq_ctrl_if.slave bus
);

  state_t            state;
  mode_t             mode;
  logic [CODE_W-1:0] key_code;
  logic [ADDR_W-1:0] accout;
  logic              ce;
  logic              rw;
  logic [CODE_W-1:0] dout;
  logic [CODE_W-1:0] code;
  logic              busy;
  logic              full;
  logic [LEN_W-1:0]  rec_len;

  assign mode = mode_t'(bus.Mode);

  pad_key_enc u_key_enc (
    .key  (bus.Key),
    .code (key_code)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      accout  <= '0;
      ce      <= 1'b0;
      rw      <= 1'b1;
      dout    <= '0;
      code    <= '0;
      busy    <= 1'b0;
      full    <= 1'b0;
      rec_len <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ce   <= 1'b0;
          rw   <= 1'b1;
          dout <= '0;
          code <= key_code;
          case (mode)
            MODE_REC: begin
              state  <= ST_REC;
              accout <= '0;
            end
            MODE_PLAY: begin
              state  <= ST_PLAY_RD;
              accout <= '0;
            end
            MODE_ERASE: begin
              state  <= ST_ERASE;
              accout <= '0;
              ce     <= 1'b1;
              rw     <= 1'b0;
              busy   <= 1'b1;
            end
            default: ;
          endcase
        end

        ST_REC: begin
          code <= key_code;
          if (ce) begin
            // Write strobe finishing: count it, then advance unless memory is exhausted.
            ce      <= 1'b0;
            rw      <= 1'b1;
            dout    <= '0;
            rec_len <= {1'b0, accout} + LEN_W'(1);
            if (accout == ADDR_MAX) full <= 1'b1;
            else                    accout <= accout + ADDR_W'(1);
          end else if (mode != MODE_REC) begin
            rec_len <= full ? LEN_W'(MEM_DEPTH) : {1'b0, accout};
            state   <= ST_IDLE;
          end else if (bus.Tick && !full) begin
            ce   <= 1'b1;
            rw   <= 1'b0;
            dout <= key_code;
          end
        end

        ST_PLAY_RD: begin
          if (mode != MODE_PLAY) begin
            state <= ST_IDLE;
          end else if (rec_len == '0) begin
            code <= '0;
          end else if (bus.Tick) begin
            ce    <= 1'b1;
            rw    <= 1'b1;
            state <= ST_PLAY_LAT;
          end
        end

        ST_PLAY_LAT: begin
          ce     <= 1'b0;
          code   <= bus.Din;
          accout <= next_play_addr(accout, rec_len);
          state  <= ST_PLAY_RD;
        end

        ST_ERASE: begin
          // Mode is deliberately ignored here so a sweep always covers the whole array.
          code <= '0;
          if (accout == ADDR_MAX) begin
            ce      <= 1'b0;
            rw      <= 1'b1;
            busy    <= 1'b0;
            full    <= 1'b0;
            rec_len <= '0;
            state   <= ST_IDLE;
          end else begin
            accout <= accout + ADDR_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          ce    <= 1'b0;
          rw    <= 1'b1;
          dout  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Accout = accout;
  assign bus.CE     = ce;
  assign bus.RW     = rw;
  assign bus.Dout   = dout;
  assign bus.Code   = code;
  assign bus.Busy   = busy;
  assign bus.Full   = full;
  assign bus.RecLen = rec_len;

endmodule

// File: doc/pad_seq_ctrl.md
PAD_SEQ_CTRL -- requirements
Module: pad_seq_ctrl

Interface
REQ-001 SHALL have port: CLK  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: Key  in  12  pad buttons, active-high; bit0..8=BTN1..BTN9, bit9=BTN_0, bit10=BTN_star, bit11=BTN_sharp.
REQ-004 SHALL have port: Mode  in  2  mode select from Dip_1/Dip_2; 00 idle, 01 record, 10 play, 11 erase.
REQ-005 SHALL have port: Tick  in  1  one-cycle sample strobe from the note-rate divider.
REQ-006 SHALL have port: Din  in  4  memory read data.
REQ-007 SHALL have port: Accout  out  12  memory address.
REQ-008 SHALL have ports: CE  out  1  memory chip enable; RW  out  1  1=read, 0=write.
REQ-009 SHALL have port: Dout  out  4  memory write data.
REQ-010 SHALL have ports: Code  out  4  note code to tone generator (0=silence); Busy  out  1  erase in progress; Full  out  1  record memory exhausted.

Function
REQ-011 Key encoding SHALL be priority, lowest bit wins; code = bit index + 1 (1..12); no key pressed = 0.
REQ-012 FSM states SHALL be IDLE, REC, PLAY_RD, PLAY_LAT, ERASE.
REQ-013 IDLE: CE=0, Code=live encoded key; Mode 01 -> REC, 10 -> PLAY_RD, 11 -> ERASE; each entry clears Accout to 0.
REQ-014 REC: on Tick with Full=0, SHALL drive CE=1, RW=0, Dout=encoded key for exactly one cycle at Accout, then increment Accout; Code=live key.
REQ-015 REC: write at Accout=4095 SHALL set Full=1, hold Accout at 4095 and suppress further writes; RecLen register SHALL hold count of words written (1..4096).
REQ-016 REC exit (Mode!=01) SHALL latch RecLen = Accout (or 4096 if Full) and return to IDLE.
REQ-017 PLAY_RD: on Tick SHALL drive CE=1, RW=1 for one cycle, go to PLAY_LAT; PLAY_LAT SHALL register Din into Code (read latency 1 cycle), increment Accout, return to PLAY_RD.
REQ-018 Play SHALL wrap Accout to 0 when incremented value equals RecLen (loop); RecLen=0 SHALL keep Code=0 and issue no reads.
REQ-019 Tick arriving during PLAY_LAT SHALL be ignored (no queuing).
REQ-020 ERASE: SHALL write 0 to every address 0..4095, one per clock (CE=1, RW=0), Busy=1, Tick ignored; after address 4095 SHALL clear RecLen, Full, Busy and go to IDLE.
REQ-021 Mode change SHALL be sampled only when no access is active (CE=0) except ERASE, which SHALL run to completion regardless of Mode.
REQ-022 Outside active access cycles CE SHALL be 0, RW SHALL be 1, Dout SHALL be 0.

Reset
REQ-023 RST SHALL asynchronously force state IDLE, Accout=0, CE=0, RW=1, Dout=0, Code=0, Busy=0, Full=0, RecLen=0.
REQ-024 RST asserted mid-access SHALL drop CE in the same instant; no partial write is retried after release.

Structure
REQ-025 Shared package SHALL hold state encodings, mode codes (MODE_IDLE/REC/PLAY/ERASE), ADDR_W=12, CODE_W=4, MEM_DEPTH=4096.
REQ-026 Key priority encoder SHALL be a separate sub-module pad_key_enc (12-bit in, 4-bit code out, purely combinational).

Verification
REQ-027 Key=0x001 and 0x040 together, Mode=00 -> Code=1; Key=0x800 only -> Code=12; Key=0 -> Code=0.
REQ-028 Mode=01, 3 Ticks with BTN1, BTN7, BTN_0 -> writes (addr,data) (0,1),(1,7),(2,10); Mode=00 -> RecLen=3.
REQ-029 Then Mode=10, 4 Ticks -> reads addr 0,1,2,0; Code sequence 1,7,10,1 each one cycle after CE read pulse.
REQ-030 Record 4096 Ticks -> Full=1 after write at 4095; 4097th Tick -> no CE pulse, Accout stays 4095.
REQ-031 Mode=11 -> Busy=1 for 4096 cycles, 4096 zero writes, then Busy=0, RecLen=0; Mode=10 -> no reads, Code=0.
REQ-032 RST pulse during PLAY_LAT -> CE=0, Code=0, Accout=0 immediately; after release with Mode=10 playback restarts at address 0.
